// File: rtl/soc_mem_arbiter.sv
// N-channel memory arbiter: fixed or round-robin selection onto one downstream
// request/response port, with optional timeout abort and late-reply drain.
module soc_mem_arbiter #(
  parameter int                N_CH     = 2,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                RR       = 1,
  parameter int                TIMEOUT  = 0,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_CH-1:0]            ch_reqValid,
  input  logic [N_CH*ADDR_W-1:0]     ch_addr,
  input  logic [N_CH*2-1:0]          ch_size,
  input  logic [N_CH-1:0]            ch_wen,
  input  logic [N_CH*DATA_W-1:0]     ch_wdata,
  input  logic [N_CH*(DATA_W/8)-1:0] ch_wmask,
  output logic [N_CH-1:0]            ch_respValid,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       mem_reqValid,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [1:0]                 mem_size,
  output logic                       mem_wen,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_wmask,
  input  logic                       mem_respValid,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(N_CH)-1:0]    grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int GW        = $clog2(N_CH);
  localparam int MW        = DATA_W / 8;
  localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_LAST_I);
  localparam logic [GW-1:0] LAST_INIT = GW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [GW-1:0] last_grant;
  logic          any_req;
  logic [GW-1:0] winner;
  logic [GW-1:0] idx;
  logic          real_resp;
  logic          expire;

  // Round-robin search starts one past the previous winner and wraps.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (RR != 0) idx = GW'((32'(last_grant) + 32'd1 + k) % N_CH);
      else         idx = GW'(k);
      if (!any_req && ch_reqValid[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  assign real_resp = (state == BUSY) && mem_respValid;
  assign expire    = (TIMEOUT > 0) && (state == BUSY) && !mem_respValid && (count == TO_LAST);

  // Responses are combinational; a reset cycle suppresses any pulse for the aborted request.
  always_comb begin
    ch_respValid = '0;
    ch_rdata     = '0;
    timeout_err  = 1'b0;
    if (!reset) begin
      if (real_resp) begin
        ch_respValid[grant_id] = 1'b1;
        ch_rdata               = mem_rdata;
      end else if (expire) begin
        ch_respValid[grant_id] = 1'b1;
        ch_rdata               = ERR_DATA;
        timeout_err            = 1'b1;
      end
    end
  end

  assign mem_reqValid = (state == BUSY);
  assign busy         = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= LAST_INIT;
      grant_id   <= '0;
      mem_addr   <= '0;
      mem_size   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= BUSY;
            count      <= '0;
            grant_id   <= winner;
            last_grant <= winner;
            mem_addr   <= ch_addr[winner*ADDR_W +: ADDR_W];
            mem_size   <= ch_size[winner*2 +: 2];
            mem_wen    <= ch_wen[winner];
            mem_wdata  <= ch_wdata[winner*DATA_W +: DATA_W];
            mem_wmask  <= ch_wmask[winner*MW +: MW];
          end
        end
        BUSY: begin
          if (mem_respValid)  state <= IDLE;
          else if (expire)    state <= DRAIN;
          else if (count != '1) count <= count + 1'b1;
        end
        DRAIN: begin
          if (mem_respValid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Bench for soc_mem_arbiter: a round-robin/timeout instance and a fixed-priority
// instance, each checked every cycle against a transaction-level model.
module tb_soc_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  req    [2];
  logic [95:0] addr   [2];
  logic [5:0]  size   [2];
  logic [2:0]  wen    [2];
  logic [95:0] wdata  [2];
  logic [11:0] wmask  [2];
  logic [2:0]  resp   [2];
  logic [31:0] rdata  [2];
  logic        mreq   [2];
  logic [31:0] maddr  [2];
  logic [1:0]  msize  [2];
  logic        mwen   [2];
  logic [31:0] mwdata [2];
  logic [3:0]  mwmask [2];
  logic        mresp  [2];
  logic [31:0] mrdata [2];
  logic [1:0]  gid    [2];
  logic        busy   [2];
  logic        terr   [2];

  soc_mem_arbiter #(.N_CH(3), .ADDR_W(32), .DATA_W(32), .RR(1), .TIMEOUT(8),
                    .ERR_DATA(32'hDEADBEEF)) u_rr (
    .clock(clock), .reset(reset),
    .ch_reqValid(req[0]), .ch_addr(addr[0]), .ch_size(size[0]), .ch_wen(wen[0]),
    .ch_wdata(wdata[0]), .ch_wmask(wmask[0]),
    .ch_respValid(resp[0]), .ch_rdata(rdata[0]),
    .mem_reqValid(mreq[0]), .mem_addr(maddr[0]), .mem_size(msize[0]), .mem_wen(mwen[0]),
    .mem_wdata(mwdata[0]), .mem_wmask(mwmask[0]),
    .mem_respValid(mresp[0]), .mem_rdata(mrdata[0]),
    .grant_id(gid[0]), .busy(busy[0]), .timeout_err(terr[0])
  );

  soc_mem_arbiter #(.N_CH(3), .ADDR_W(32), .DATA_W(32), .RR(0), .TIMEOUT(0),
                    .ERR_DATA(32'hDEADBEEF)) u_fp (
    .clock(clock), .reset(reset),
    .ch_reqValid(req[1]), .ch_addr(addr[1]), .ch_size(size[1]), .ch_wen(wen[1]),
    .ch_wdata(wdata[1]), .ch_wmask(wmask[1]),
    .ch_respValid(resp[1]), .ch_rdata(rdata[1]),
    .mem_reqValid(mreq[1]), .mem_addr(maddr[1]), .mem_size(msize[1]), .mem_wen(mwen[1]),
    .mem_wdata(mwdata[1]), .mem_wmask(mwmask[1]),
    .mem_respValid(mresp[1]), .mem_rdata(mrdata[1]),
    .grant_id(gid[1]), .busy(busy[1]), .timeout_err(terr[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (u%0d) at %0t: got %h, expected %h", name, m, $time, act, exp);
    end
  endtask

  function automatic int to_of(input int m);
    return (m == 0) ? 8 : 0;
  endfunction

  function automatic bit rr_of(input int m);
    return (m == 0);
  endfunction

  // Model: who owns the port, whether a late reply is owed, and how long it has waited.
  bit          started = 1'b0;
  int          owner [2];
  bit          drain [2];
  int          age   [2];
  int          last  [2];
  int          gsel  [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wdata[2];
  logic [6:0]  e_ctrl [2];
  logic [2:0]  seen   [2];

  function automatic int pick(input int m);
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = rr_of(m) ? (last[m] + k) % 3 : k - 1;
      if (req[m][c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      started = 1'b1;
      for (int m = 0; m < 2; m++) begin
        owner[m] = -1; drain[m] = 1'b0; age[m] = 0; last[m] = 2; gsel[m] = 0;
        e_addr[m] = '0; e_wdata[m] = '0; e_ctrl[m] = '0;
      end
    end else if (started) begin
      for (int m = 0; m < 2; m++) begin
        if (drain[m]) begin
          if (mresp[m]) drain[m] = 1'b0;
        end else if (owner[m] >= 0) begin
          if (mresp[m]) owner[m] = -1;
          else if (to_of(m) > 0 && age[m] == to_of(m) - 1) begin
            owner[m] = -1;
            drain[m] = 1'b1;
          end else age[m]++;
        end else begin
          int c;
          c = pick(m);
          if (c >= 0) begin
            owner[m] = c; last[m] = c; gsel[m] = c; age[m] = 0;
            e_addr[m]  = addr[m][c*32 +: 32];
            e_wdata[m] = wdata[m][c*32 +: 32];
            e_ctrl[m]  = {wen[m][c], size[m][c*2 +: 2], wmask[m][c*4 +: 4]};
          end
        end
      end
    end
  end

  logic [2:0]  er;
  logic [31:0] ed;
  logic        et;

  always @(negedge clock) begin
    if (started) begin
      for (int m = 0; m < 2; m++) begin
        er = '0; ed = '0; et = 1'b0;
        if (!reset && owner[m] >= 0) begin
          if (mresp[m]) begin
            er[owner[m]] = 1'b1; ed = mrdata[m];
          end else if (to_of(m) > 0 && age[m] == to_of(m) - 1) begin
            er[owner[m]] = 1'b1; ed = 32'hDEADBEEF; et = 1'b1;
          end
        end
        chk("resp_valid", m, 32'(resp[m]), 32'(er));
        chk("resp_data", m, rdata[m], ed);
        chk("timeout_err", m, 32'(terr[m]), 32'(et));
        chk("mem_reqValid", m, 32'(mreq[m]), 32'(owner[m] >= 0));
        chk("busy", m, 32'(busy[m]), 32'(owner[m] >= 0 || drain[m]));
        chk("grant_id", m, 32'(gid[m]), gsel[m]);
        chk("mem_addr", m, maddr[m], e_addr[m]);
        chk("mem_wdata", m, mwdata[m], e_wdata[m]);
        chk("mem_ctrl", m, 32'({mwen[m], msize[m], mwmask[m]}), 32'(e_ctrl[m]));
        seen[m] = resp[m];
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    for (int m = 0; m < 2; m++) begin
      req[m] = '0; addr[m] = '0; size[m] = '0; wen[m] = '0;
      wdata[m] = '0; wmask[m] = '0; mresp[m] = 1'b0; mrdata[m] = '0;
    end
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int gq0[$];
  int gq1[$];

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    for (int m = 0; m < 2; m++) begin
      chk("rst_mreq", m, 32'(mreq[m]), 32'd0);
      chk("rst_busy", m, 32'(busy[m]), 32'd0);
      chk("rst_grant", m, 32'(gid[m]), 32'd0);
      chk("rst_addr", m, maddr[m], 32'd0);
      chk("rst_resp", m, 32'(resp[m]), 32'd0);
    end

    // Single IFU read, reply three cycles after the request appears downstream.
    do_reset();
    req[0] = 3'b001; addr[0][31:0] = 32'h3000_0000; size[0][1:0] = 2'd2;
    @(negedge clock); chk("t1_idle_mreq", 0, 32'(mreq[0]), 32'd0);
    tick();
    @(negedge clock);
    chk("t1_mreq", 0, 32'(mreq[0]), 32'd1);
    chk("t1_addr", 0, maddr[0], 32'h3000_0000);
    tick(); tick(); tick();
    mresp[0] = 1'b1; mrdata[0] = 32'h1234_5678;
    @(negedge clock);
    chk("t1_resp", 0, 32'(resp[0]), 32'd1);
    chk("t1_rdata", 0, rdata[0], 32'h1234_5678);
    tick();
    mresp[0] = 1'b0; req[0] = '0;
    @(negedge clock);
    chk("t1_busy_after", 0, 32'(busy[0]), 32'd0);

    // Contention on channels 0 and 1, replying in the first BUSY cycle.
    do_reset();
    req[0] = 3'b011; req[1] = 3'b011;
    for (int cyc = 0; cyc < 30 && !(gq0.size() >= 4 && gq1.size() >= 4); cyc++) begin
      tick();
      mresp[0] = mreq[0] && (gq0.size() < 4);
      mresp[1] = mreq[1] && (gq1.size() < 4);
      @(negedge clock);
      if (mresp[0]) gq0.push_back(int'(gid[0]));
      if (mresp[1]) gq1.push_back(int'(gid[1]));
    end
    tick();
    clear_inputs();
    chk("t2_rr_count", 0, gq0.size(), 32'd4);
    chk("t2_fp_count", 1, gq1.size(), 32'd4);
    for (int i = 0; i < 4 && i < gq0.size(); i++) chk("t2_rr_grant", 0, gq0[i], i % 2);
    for (int i = 0; i < 4 && i < gq1.size(); i++) chk("t2_fp_grant", 1, gq1[i], 32'd0);

    // LSU half-word write: latched fields must hold for every BUSY cycle.
    do_reset();
    req[0] = 3'b010; addr[0][63:32] = 32'h4000_0010; size[0][3:2] = 2'd1;
    wen[0][1] = 1'b1; wdata[0][63:32] = 32'hA5A5_0F0F; wmask[0][7:4] = 4'b0011;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t3_addr", 0, maddr[0], 32'h4000_0010);
      chk("t3_wdata", 0, mwdata[0], 32'hA5A5_0F0F);
      chk("t3_ctrl", 0, 32'({mwen[0], msize[0], mwmask[0]}), 32'b1_01_0011);
      chk("t3_grant", 0, 32'(gid[0]), 32'd1);
      tick();
    end
    mresp[0] = 1'b1;
    @(negedge clock); chk("t3_resp", 0, 32'(resp[0]), 32'b010);
    tick();
    clear_inputs();

    // Timeout after 8 BUSY cycles, then drain a late reply; a new request must wait.
    do_reset();
    req[0] = 3'b001;
    tick();
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock); chk("t4_no_early_resp", 0, 32'(resp[0]), 32'd0);
      tick();
    end
    @(negedge clock);
    chk("t4_resp", 0, 32'(resp[0]), 32'b001);
    chk("t4_rdata", 0, rdata[0], 32'hDEADBEEF);
    chk("t4_terr", 0, 32'(terr[0]), 32'd1);
    tick();
    req[0] = 3'b010;
    @(negedge clock);
    chk("t4_drain_mreq", 0, 32'(mreq[0]), 32'd0);
    chk("t4_drain_busy", 0, 32'(busy[0]), 32'd1);
    tick();
    mresp[0] = 1'b1; mrdata[0] = 32'h0000_0055;
    @(negedge clock);
    chk("t4_late_resp", 0, 32'(resp[0]), 32'd0);
    chk("t4_late_rdata", 0, rdata[0], 32'd0);
    tick();
    mresp[0] = 1'b0;
    @(negedge clock); chk("t4_idle_busy", 0, 32'(busy[0]), 32'd0);
    tick();
    @(negedge clock);
    chk("t4_regrant_mreq", 0, 32'(mreq[0]), 32'd1);
    chk("t4_regrant_id", 0, 32'(gid[0]), 32'd1);
    tick();
    mresp[0] = 1'b1;
    tick();
    clear_inputs();

    // Reply arriving in the expiry cycle wins over the timeout.
    do_reset();
    req[0] = 3'b001;
    tick();
    repeat (7) tick();
    mresp[0] = 1'b1; mrdata[0] = 32'h0BAD_F00D;
    @(negedge clock);
    chk("t5_resp", 0, 32'(resp[0]), 32'b001);
    chk("t5_rdata", 0, rdata[0], 32'h0BAD_F00D);
    chk("t5_terr", 0, 32'(terr[0]), 32'd0);
    tick();
    clear_inputs();
    @(negedge clock); chk("t5_busy_after", 0, 32'(busy[0]), 32'd0);

    // Reset two cycles into BUSY; a later reply must produce nothing.
    do_reset();
    req[0] = 3'b001;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req[0] = '0;
    @(negedge clock);
    chk("t6_mreq", 0, 32'(mreq[0]), 32'd0);
    chk("t6_busy", 0, 32'(busy[0]), 32'd0);
    tick();
    mresp[0] = 1'b1; mrdata[0] = 32'h0000_0077;
    @(negedge clock);
    chk("t6_late_resp", 0, 32'(resp[0]), 32'd0);
    chk("t6_late_rdata", 0, rdata[0], 32'd0);
    tick();

    // Randomised traffic obeying the hold-until-response channel protocol.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < 3; c++) begin
          if (!req[m][c] || seen[m][c]) begin
            if ($urandom_range(0, 2) != 0) begin
              req[m][c]            = 1'b1;
              addr[m][c*32 +: 32]  = $urandom;
              size[m][c*2 +: 2]    = 2'($urandom_range(0, 2));
              wen[m][c]            = 1'($urandom_range(0, 1));
              wdata[m][c*32 +: 32] = $urandom;
              wmask[m][c*4 +: 4]   = 4'($urandom_range(0, 15));
            end else begin
              req[m][c] = 1'b0;
            end
          end
        end
        if (mreq[m]) mresp[m] = ($urandom_range(0, 3) == 0);
        else         mresp[m] = ($urandom_range(0, 5) == 0);
        mrdata[m] = $urandom;
      end
    end
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
